instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 163 ++++++++++++++++
 tb/tb_instr_encoder.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32 instruction encoder: turns decoded fields back into a 32-bit word, flags
// unencodable requests, and buffers results in a DEPTH-entry output FIFO.
module instr_encoder #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_illegal,
    output logic [7:0]  illegal_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    function automatic logic [31:0] encode_word(
        input logic [2:0]  fmt,
        input logic [6:0]  op,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [31:0] w;
        w = 32'h0;
        case (fmt)
            FMT_R:   w = {f7, rs2, rs1, f3, rd, op};
            FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
            FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   w = {imm[31:12], rd, op};
            FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // An immediate fits N signed bits when bits [31:N-1] are all equal.
    function automatic logic is_legal(
        input logic [2:0]  fmt,
        input logic [6:0]  op,
        input logic [31:0] imm
    );
        logic ok;
        ok = 1'b0;
        case (fmt)
            FMT_R:   ok = 1'b1;
            FMT_I,
            FMT_S:   ok = (&imm[31:11]) | ~(|imm[31:11]);
            FMT_B:   ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
            FMT_U:   ok = ~(|imm[11:0]);
            FMT_J:   ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
            default: ok = 1'b0;
        endcase
        return ok & (op[1:0] == 2'b11);
    endfunction

    logic [31:0]      mem_instr_q [DEPTH];
    logic [DEPTH-1:0] mem_ill_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       ill_cnt_q, ill_cnt_d;

    logic        legal_s;
    logic [31:0] word_s;
    logic        push_s;
    logic        pop_s;

    // Combinational encode and legality check of the incoming request.
    always_comb begin
        legal_s = is_legal(in_fmt, in_opcode, in_imm);
        if (legal_s) begin
            word_s = encode_word(in_fmt, in_opcode, in_funct3, in_funct7,
                                 in_rd, in_rs1, in_rs2, in_imm);
        end else begin
            word_s = 32'h0;
        end
    end

    assign in_ready      = (count_q < DEPTH_C) && !rst;
    assign push_s        = in_valid && in_ready;
    assign out_valid     = (count_q != {CNT_W{1'b0}});
    assign pop_s         = out_valid && out_ready;
    assign out_instr     = out_valid ? mem_instr_q[rd_ptr_q] : 32'h0;
    assign out_illegal   = out_valid & mem_ill_q[rd_ptr_q];
    assign illegal_count = ill_cnt_q;

    // Next-state for pointers, occupancy and the saturating illegal counter.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ill_cnt_d = ill_cnt_q;
        if (push_s) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (push_s && !legal_s && (ill_cnt_q != 8'hFF)) begin
            ill_cnt_d = ill_cnt_q + 8'd1;
        end else begin
            ill_cnt_d = ill_cnt_q;
        end
    end

    // State registers and FIFO storage; reset discards all buffered entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            count_q   <= {CNT_W{1'b0}};
            ill_cnt_q <= 8'h00;
            mem_ill_q <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr_q[i] <= 32'h0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ill_cnt_q <= ill_cnt_d;
            if (push_s) begin
                mem_instr_q[wr_ptr_q] <= word_s;
                mem_ill_q[wr_ptr_q]   <= ~legal_s;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors, back-pressure,
// reset while full, counter saturation and a randomized scoreboard run.
module tb_instr_encoder;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_illegal;
    logic [7:0]  illegal_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } req_t;

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_illegal(out_illegal),
        .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    function automatic req_t mk(input logic [2:0] fmt, input logic [6:0] op,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm);
        req_t r;
        r.fmt = fmt; r.op = op; r.f3 = f3; r.f7 = f7;
        r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
        return r;
    endfunction

    task automatic drive(input req_t r, input logic v);
        in_valid  = v;
        in_fmt    = r.fmt;
        in_opcode = r.op;
        in_funct3 = r.f3;
        in_funct7 = r.f7;
        in_rd     = r.rd;
        in_rs1    = r.rs1;
        in_rs2    = r.rs2;
        in_imm    = r.imm;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Legality from numeric ranges of the signed immediate.
    function automatic bit legal_model(input req_t r);
        int s;
        s = $signed(r.imm);
        if (r.fmt > 3'd5 || r.op[1:0] != 2'b11) return 1'b0;
        case (r.fmt)
            3'd0:    return 1'b1;
            3'd1,
            3'd2:    return (s >= -2048 && s <= 2047);
            3'd3:    return (s >= -4096 && s <= 4095 && (s % 2) == 0);
            3'd4:    return ((r.imm & 32'h0000_0FFF) == 32'h0);
            3'd5:    return (s >= -1048576 && s <= 1048575 && (s % 2) == 0);
            default: return 1'b0;
        endcase
    endfunction

    // Random word is decoded into fields; the encoder must rebuild that word.
    task automatic gen_req(output req_t r, output logic [31:0] exp_w, output logic exp_ill);
        logic [31:0] w;
        int kind;
        w = $urandom;
        w[1:0] = 2'b11;
        r.fmt = 3'($urandom_range(0, 5));
        r.op = w[6:0];
        r.f3 = w[14:12];
        r.rd = w[11:7];
        r.rs1 = w[19:15];
        r.rs2 = w[24:20];
        r.f7 = w[31:25];
        r.imm = $urandom;
        case (r.fmt)
            3'd1: begin
                r.imm = {{20{w[31]}}, w[31:20]};
                r.rs2 = 5'($urandom); r.f7 = 7'($urandom);
            end
            3'd2: begin
                r.imm = {{20{w[31]}}, w[31:25], w[11:7]};
                r.rd = 5'($urandom); r.f7 = 7'($urandom);
            end
            3'd3: begin
                r.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                r.rd = 5'($urandom); r.f7 = 7'($urandom);
            end
            3'd4: begin
                r.imm = {w[31:12], 12'h000};
                r.f3 = 3'($urandom); r.rs1 = 5'($urandom);
                r.rs2 = 5'($urandom); r.f7 = 7'($urandom);
            end
            3'd5: begin
                r.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
                r.f3 = 3'($urandom); r.rs1 = 5'($urandom);
                r.rs2 = 5'($urandom); r.f7 = 7'($urandom);
            end
            default: ;
        endcase
        kind = $urandom_range(0, 7);
        if (kind == 0) begin
            r.fmt = 3'($urandom_range(6, 7));
        end else if (kind == 1) begin
            r.op[1:0] = 2'($urandom_range(0, 2));
        end else if (kind == 2) begin
            case (r.fmt)
                3'd1, 3'd2: r.imm[$urandom_range(12, 31)] ^= 1'b1;
                3'd3:       if ($urandom_range(0, 1) == 0) r.imm[0] = 1'b1;
                            else r.imm[$urandom_range(13, 31)] ^= 1'b1;
                3'd4:       r.imm[$urandom_range(0, 11)] ^= 1'b1;
                3'd5:       if ($urandom_range(0, 1) == 0) r.imm[0] = 1'b1;
                            else r.imm[$urandom_range(21, 31)] ^= 1'b1;
                default:    r.imm = $urandom;
            endcase
        end
        exp_ill = !legal_model(r);
        exp_w = exp_ill ? 32'h0 : w;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        out_ready = 1'b1;
        drive(mk(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0), 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b instr=%h illegal=%b, required 0/0/0",
                     out_valid, out_instr, out_illegal);
        end
        checks++;
        if (illegal_count !== 8'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_count_ready: count=%0d ready=%b, required 0/0",
                     illegal_count, in_ready);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b required 1", in_ready);
        end
    endtask

    task automatic test_known_vectors;
        req_t        v   [8];
        logic [31:0] exw [8];
        logic        exi [8];
        logic [7:0]  exc [8];
        do_reset();
        v[0] = mk(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        exw[0] = 32'h002081B3; exi[0] = 1'b0; exc[0] = 8'd0;
        v[1] = mk(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        exw[1] = 32'h00500093; exi[1] = 1'b0; exc[1] = 8'd0;
        v[2] = mk(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
        exw[2] = 32'hFE208EE3; exi[2] = 1'b0; exc[2] = 8'd0;
        v[3] = mk(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
        exw[3] = 32'h123452B7; exi[3] = 1'b0; exc[3] = 8'd0;
        v[4] = mk(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3);
        exw[4] = 32'h0; exi[4] = 1'b1; exc[4] = 8'd1;
        v[5] = mk(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        exw[5] = 32'h0; exi[5] = 1'b1; exc[5] = 8'd2;
        v[6] = mk(3'd2, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        exw[6] = 32'h0020A423; exi[6] = 1'b0; exc[6] = 8'd2;
        v[7] = mk(3'd6, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        exw[7] = 32'h0; exi[7] = 1'b1; exc[7] = 8'd3;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL vec%0d_idle: valid=%b ready=%b, required 0/1",
                         i, out_valid, in_ready);
            end
            drive(v[i], 1'b1);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_instr !== exw[i] || out_illegal !== exi[i]) begin
                errors++;
                $display("FAIL vec%0d_out: valid=%b instr=%h ill=%b, required 1/%h/%b",
                         i, out_valid, out_instr, out_illegal, exw[i], exi[i]);
            end
            checks++;
            if (illegal_count !== exc[i]) begin
                errors++;
                $display("FAIL vec%0d_count: got %0d required %0d", i, illegal_count, exc[i]);
            end
            out_ready = 1'b1;
            @(posedge clk);
        end
    endtask

    task automatic test_back_to_back;
        req_t        reqs [3];
        logic [31:0] exw  [3];
        logic [31:0] got  [$];
        int sent = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            reqs[i] = mk(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'(i + 1));
            exw[i]  = 32'h00000093 | (32'(i + 1) << 20);
        end
        for (int cyc = 0; cyc < 30 && got.size() < 3; cyc++) begin
            @(negedge clk);
            if (sent < 3) drive(reqs[sent], 1'b1);
            else in_valid = 1'b0;
            out_ready = (cyc >= 4);
            if (cyc == 2) begin
                checks++;
                if (in_ready !== 1'b0 || sent != 2) begin
                    errors++;
                    $display("FAIL full_stall: ready=%b sent=%0d, required 0/2", in_ready, sent);
                end
            end
            if (out_valid && out_ready) got.push_back(out_instr);
            if (in_valid && in_ready) sent++;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (got.size() != 3 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_delivery: delivered=%0d valid_after=%b, required 3/0",
                     got.size(), out_valid);
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exw[i]) begin
                errors++;
                $display("FAIL b2b_order%0d: got %h required %h", i, got[i], exw[i]);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_when_full;
        req_t bad;
        req_t good;
        bad  = mk(3'd7, 7'b0110011, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0);
        good = mk(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        do_reset();
        drive(bad, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || illegal_count !== 8'd2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL prefill: valid=%b count=%0d ready=%b, required 1/2/0",
                     out_valid, illegal_count, in_ready);
        end
        rst = 1'b1;
        out_ready = 1'b1;
        drive(bad, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_reset: got %b required 0", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        drive(good, 1'b1);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_illegal !== 1'b0 ||
            illegal_count !== 8'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_reset_pulse: valid=%b instr=%h ill=%b count=%0d ready=%b",
                     out_valid, out_instr, out_illegal, illegal_count, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'h00500093 || out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL first_after_reset: valid=%b instr=%h ill=%b, required 1/00500093/0",
                     out_valid, out_instr, out_illegal);
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_entry: valid=%b instr=%h, required empty", out_valid, out_instr);
        end
    endtask

    task automatic test_saturation;
        int accepted = 0;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 300 && accepted < 260; i++) begin
            @(negedge clk);
            if (accepted == 254) begin
                checks++;
                if (illegal_count !== 8'd254) begin
                    errors++;
                    $display("FAIL count_254: got %0d required 254", illegal_count);
                end
            end
            drive(mk(3'd7, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0), 1'b1);
            if (in_ready) accepted++;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (accepted != 260 || illegal_count !== 8'd255) begin
            errors++;
            $display("FAIL saturation: accepted=%0d count=%0d, required 260/255",
                     accepted, illegal_count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [32:0] q [$];
        int          ill_m = 0;
        req_t        r;
        logic [31:0] ew;
        logic        ei;
        bit          do_push, do_pop;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            gen_req(r, ew, ei);
            drive(r, ($urandom_range(0, 9) < 7));
            out_ready = ($urandom_range(0, 9) < 6);
            checks++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < DEPTH) ||
                illegal_count !== 8'(ill_m)) begin
                errors++;
                $display("FAIL rand_status cyc%0d: valid=%b ready=%b count=%0d, model size=%0d count=%0d",
                         cyc, out_valid, in_ready, illegal_count, q.size(), ill_m);
            end
            if (q.size() != 0) begin
                checks++;
                if ({out_illegal, out_instr} !== q[0]) begin
                    errors++;
                    $display("FAIL rand_head cyc%0d: got %b/%h required %b/%h",
                             cyc, out_illegal, out_instr, q[0][32], q[0][31:0]);
                end
            end
            do_push = in_valid && (q.size() < DEPTH);
            do_pop  = out_ready && (q.size() != 0);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back({ei, ew});
                if (ei && ill_m < 255) ill_m++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        drive(mk(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0), 1'b0);
        test_reset();
        test_known_vectors();
        test_back_to_back();
        test_reset_when_full();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
